axil_mem_ctrl: RTL and testbench

- AXI4-Lite slave front end that sequences the team's single-port-write / single-port-read word memory (byte-strobed write, 1-cycle registered read).
- Runs independent write and read channel FSMs and converts byte addresses to word indices.
- Drives memory write and read strobes for exactly one cycle per transaction, then returns B/R responses.
- Sits between the interconnect and the memory instance.

---
 rtl/axil_mem_pkg.sv | 39 +++
 rtl/axil_mem_wr_chan.sv | 109 ++++++++++
 rtl/axil_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_axil_mem_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mem_pkg.sv
// axil_mem_pkg: shared definitions for the AXI4-Lite memory controller.
//   - AXI response codes (OKAY / SLVERR)
//   - write and read channel state enums
//   - byte-address to word-index helper and address-legality helper
// Build option: AXIL_ADDR_CHECK_EN (used by the importing modules).
package axil_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_RESP
  } rd_state_t;

  // Drops the byte-offset bits; callers size-cast the result to their
  // word-index width, which is where upper-bit aliasing happens.
  function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                             input int unsigned off_bits);
    return byte_addr >> off_bits;
  endfunction

  // True for an address past the end of the memory or not word aligned.
  function automatic logic addr_bad(input logic [63:0] byte_addr,
                                    input logic [63:0] limit_bytes,
                                    input logic [63:0] align_mask);
    return (byte_addr >= limit_bytes) || ((byte_addr & align_mask) != 64'd0);
  endfunction

endpackage

// File: rtl/axil_mem_wr_chan.sv
// axil_mem_wr_chan: AXI4-Lite write channel sequencer.
// Accepts AW and W in either order (or together), issues one memory write
// strobe with the captured index/strobe/data, then returns a B response.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*               AXI4-Lite write address/data/response
//   mem_wen/mem_waddr/mem_wstrb/mem_wdata   memory write port
// Build option: AXIL_ADDR_CHECK_EN -> out-of-range or misaligned writes
// are suppressed and answered with SLVERR; otherwise addresses alias.
import axil_mem_pkg::*;

module axil_mem_wr_chan #(
  parameter int dataWidth    = 32,
  parameter int dataDepth    = 64,
  parameter int axiAddrWidth = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [axiAddrWidth-1:0]      s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [dataWidth-1:0]         s_wdata,
  input  logic [dataWidth/8-1:0]       s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic                         mem_wen,
  output logic [$clog2(dataDepth)-1:0] mem_waddr,
  output logic [dataWidth/8-1:0]       mem_wstrb,
  output logic [dataWidth-1:0]         mem_wdata
);

  localparam int          strbWidth = dataWidth / 8;
  localparam int          addrWidth = $clog2(dataDepth);
  localparam int unsigned offBits   = $clog2(strbWidth);

  wr_state_t              state_q, state_d;
  logic [addrWidth-1:0]   waddr_q, waddr_d;
  logic [strbWidth-1:0]   wstrb_q, wstrb_d;
  logic [dataWidth-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   aw_hs, w_hs, aw_err;

`ifdef AXIL_ADDR_CHECK_EN
  assign aw_err = addr_bad(64'(s_awaddr), 64'(dataDepth * strbWidth), 64'(strbWidth - 1));
`else
  assign aw_err = 1'b0;
`endif

  // READY depends only on state, never on VALID.
  assign s_awready = (state_q == WR_IDLE) || (state_q == WR_HAVE_W);
  assign s_wready  = (state_q == WR_IDLE) || (state_q == WR_HAVE_AW);
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs)  state_d = WR_COMMIT;
        else if (aw_hs)     state_d = WR_HAVE_AW;
        else if (w_hs)      state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)     state_d = WR_COMMIT;
      WR_HAVE_W:  if (aw_hs)    state_d = WR_COMMIT;
      WR_COMMIT:                state_d = WR_RESP;
      WR_RESP:    if (s_bready) state_d = WR_IDLE;
      default:                  state_d = WR_IDLE;
    endcase
    if (aw_hs) begin
      waddr_d = addrWidth'(word_index(64'(s_awaddr), offBits));
      err_d   = aw_err;
    end
    if (w_hs) begin
      wstrb_d = s_wstrb;
      wdata_d = s_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WR_IDLE;
      waddr_q <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_wen   = (state_q == WR_COMMIT) && !err_q;
  assign mem_waddr = waddr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign s_bvalid  = (state_q == WR_RESP);
  assign s_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: rtl/axil_mem_ctrl.sv
// axil_mem_ctrl: AXI4-Lite slave front end for a word memory with a
// byte-strobed write port and a 1-cycle registered read port.
// Write and read channels run independently; each allows one outstanding
// transaction and pulses its memory strobe for exactly one cycle.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*                 AXI4-Lite write channels
//   s_ar*/s_r*                      AXI4-Lite read channels
//   mem_w*                          memory write port
//   mem_ren/mem_raddr/mem_rdata     memory read port (rdata registered)
// Build option: AXIL_ADDR_CHECK_EN -> out-of-range or misaligned accesses
// get SLVERR with no memory strobe (read data forced to 0).
import axil_mem_pkg::*;

module axil_mem_ctrl #(
  parameter int dataWidth    = 32,
  parameter int dataDepth    = 64,
  parameter int axiAddrWidth = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [axiAddrWidth-1:0]      s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [dataWidth-1:0]         s_wdata,
  input  logic [dataWidth/8-1:0]       s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [axiAddrWidth-1:0]      s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [dataWidth-1:0]         s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic                         mem_wen,
  output logic [$clog2(dataDepth)-1:0] mem_waddr,
  output logic [dataWidth/8-1:0]       mem_wstrb,
  output logic [dataWidth-1:0]         mem_wdata,
  output logic                         mem_ren,
  output logic [$clog2(dataDepth)-1:0] mem_raddr,
  input  logic [dataWidth-1:0]         mem_rdata
);

  localparam int          strbWidth = dataWidth / 8;
  localparam int          addrWidth = $clog2(dataDepth);
  localparam int unsigned offBits   = $clog2(strbWidth);

  axil_mem_wr_chan #(
    .dataWidth   (dataWidth),
    .dataDepth   (dataDepth),
    .axiAddrWidth(axiAddrWidth)
  ) u_wr_chan (
    .clk      (clk),
    .reset    (reset),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .mem_wen  (mem_wen),
    .mem_waddr(mem_waddr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata)
  );

  rd_state_t            rd_state_q, rd_state_d;
  logic [addrWidth-1:0] raddr_q, raddr_d;
  logic                 rerr_q, rerr_d;
  logic                 ar_hs, ar_err;

`ifdef AXIL_ADDR_CHECK_EN
  assign ar_err = addr_bad(64'(s_araddr), 64'(dataDepth * strbWidth), 64'(strbWidth - 1));
`else
  assign ar_err = 1'b0;
`endif

  assign s_arready = (rd_state_q == RD_IDLE);
  assign ar_hs     = s_arvalid && s_arready;

  always_comb begin
    rd_state_d = rd_state_q;
    raddr_d    = raddr_q;
    rerr_d     = rerr_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_ISSUE;
          raddr_d    = addrWidth'(word_index(64'(s_araddr), offBits));
          rerr_d     = ar_err;
        end
      end
      RD_ISSUE:               rd_state_d = RD_RESP;
      RD_RESP: if (s_rready)  rd_state_d = RD_IDLE;
      default:                rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      raddr_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      raddr_q    <= raddr_d;
      rerr_q     <= rerr_d;
    end
  end

  assign mem_ren   = (rd_state_q == RD_ISSUE) && !rerr_q;
  assign mem_raddr = raddr_q;
  assign s_rvalid  = (rd_state_q == RD_RESP);
  assign s_rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;
  // Memory output register holds its value while mem_ren stays low, so
  // passing it straight through keeps RDATA stable under backpressure.
  assign s_rdata   = rerr_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_axil_mem_ctrl.sv
// tb_axil_mem_ctrl: self-checking bench for axil_mem_ctrl.
// Contains a byte-strobed memory with registered read attached to the
// DUT memory port, and a word-array reference model updated from the
// AXI transactions the bench issues.
// Build option: AXIL_ADDR_CHECK_EN selects the address-check expectations.
module tb_axil_mem_ctrl;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk, reset;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, mem_wdata, mem_rdata;
  logic [3:0]  s_wstrb, mem_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, mem_wen, mem_ren;
  logic [1:0]  s_bresp, s_rresp;
  logic [5:0]  mem_waddr, mem_raddr;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  bit          mem_clear;

  axil_mem_ctrl #(.dataWidth(32), .dataDepth(64), .axiAddrWidth(32)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory instance stand-in: registered read sees pre-write contents.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem_rdata <= 32'd0;
    end else begin
      if (mem_ren) mem_rdata <= mem[mem_raddr];
      if (mem_wen)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_idx(input logic [31:0] a);
    return int'((a / 4) % 64);
  endfunction

  function automatic bit ref_bad(input logic [31:0] a);
`ifdef AXIL_ADDR_CHECK_EN
    return (a >= 32'd256) || (a % 4 != 0);
`else
    return (a != a);
`endif
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!ref_bad(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[ref_idx(a)][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // ---------------- drivers (return observations) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int wen_cnt, output int wen_ofs,
                           output int bv_ofs, output int widx, output bit to);
    int cyc = 0, hs_cyc = -1, bv_first = -1;
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
    resp = 2'bxx; wen_cnt = 0; wen_ofs = -1; bv_ofs = -1; widx = -1; to = 0;
    while (!b_done) begin
      if (mem_wen) begin
        wen_cnt++;
        if (wen_ofs < 0 && hs_cyc >= 0) begin wen_ofs = cyc - hs_cyc; widx = int'(mem_waddr); end
      end
      if (s_bvalid && bv_first < 0) begin
        bv_first = cyc;
        if (hs_cyc >= 0) bv_ofs = cyc - hs_cyc;
      end
      s_awaddr = addr; s_wdata = data; s_wstrb = strb;
      s_awvalid = !aw_done && cyc >= aw_dly;
      s_wvalid  = !w_done && cyc >= w_dly;
      s_bready  = bv_first >= 0 && (cyc - bv_first) >= b_dly;
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      b_hs  = s_bvalid && s_bready;
      if (b_hs) resp = s_bresp;
      @(posedge clk); #1; cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if ((aw_hs || w_hs) && aw_done && w_done && hs_cyc < 0) hs_cyc = cyc - 1;
      if (b_hs) b_done = 1;
      if (cyc > 300) begin to = 1; break; end
    end
    if (mem_wen) wen_cnt++;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0;
    $display("WR addr=%h data=%h strb=%h resp=%b wen=%0d idx=%0d", addr, data, strb, resp, wen_cnt, widx);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] rdata, output logic [1:0] resp, output int ren_cnt,
                          output int ren_ofs, output int rv_ofs, output int ridx, output bit to);
    int cyc = 0, hs_cyc = -1, rv_first = -1;
    bit ar_done = 0, r_done = 0, ar_hs, r_hs;
    rdata = 'x; resp = 2'bxx; ren_cnt = 0; ren_ofs = -1; rv_ofs = -1; ridx = -1; to = 0;
    while (!r_done) begin
      if (mem_ren) begin
        ren_cnt++;
        if (ren_ofs < 0 && hs_cyc >= 0) begin ren_ofs = cyc - hs_cyc; ridx = int'(mem_raddr); end
      end
      if (s_rvalid && rv_first < 0) begin
        rv_first = cyc;
        if (hs_cyc >= 0) rv_ofs = cyc - hs_cyc;
      end
      s_araddr  = addr;
      s_arvalid = !ar_done && cyc >= ar_dly;
      s_rready  = rv_first >= 0 && (cyc - rv_first) >= r_dly;
      ar_hs = s_arvalid && s_arready;
      r_hs  = s_rvalid && s_rready;
      if (r_hs) begin rdata = s_rdata; resp = s_rresp; end
      @(posedge clk); #1; cyc++;
      if (ar_hs) begin ar_done = 1; hs_cyc = cyc - 1; end
      if (r_hs) r_done = 1;
      if (cyc > 300) begin to = 1; break; end
    end
    if (mem_ren) ren_cnt++;
    s_arvalid = 0; s_rready = 0;
    $display("RD addr=%h data=%h resp=%b ren=%0d idx=%0d", addr, rdata, resp, ren_cnt, ridx);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; mem_clear = 1;
    repeat (3) @(posedge clk);
    #1; reset = 0; mem_clear = 0;
    checks++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b want=111", {s_awready, s_wready, s_arready}); end
    checks++; if ({s_bvalid, s_rvalid, mem_wen, mem_ren} !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b want=0000", {s_bvalid, s_rvalid, mem_wen, mem_ren}); end
    checks++; if ({s_bresp, s_rresp} !== 4'b0000) begin failures++; $display("FAIL reset_resp got=%b want=0000", {s_bresp, s_rresp}); end
    checks++; if ({mem_waddr, mem_wstrb, mem_wdata, mem_raddr} !== 48'd0) begin failures++; $display("FAIL reset_regs got=%h want=0", {mem_waddr, mem_wstrb, mem_wdata, mem_raddr}); end
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [31:0] rd; int cnt, ofs1, ofs2, idx; bit to;
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (to !== 1'b0 || resp !== OKAY) begin failures++; $display("FAIL basic_bresp got=%b to=%0d want=%b", resp, to, OKAY); end
    checks++; if (cnt != 1 || ofs1 != 1 || ofs2 != 2) begin failures++; $display("FAIL basic_wtiming got wen=%0d/%0d bv=%0d want 1/1/2", cnt, ofs1, ofs2); end
    checks++; if (idx != 4) begin failures++; $display("FAIL basic_widx got=%0d want=4", idx); end
    axi_read(32'h10, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[4] || resp !== OKAY || to) begin failures++; $display("FAIL basic_rdata got=%h/%b want=%h/%b", rd, resp, ref_mem[4], OKAY); end
    checks++; if (cnt != 1 || ofs1 != 1 || ofs2 != 2 || idx != 4) begin failures++; $display("FAIL basic_rtiming got ren=%0d/%0d rv=%0d idx=%0d want 1/1/2/4", cnt, ofs1, ofs2, idx); end
    // zero strobe: still a write pulse, contents unchanged
    axi_write(32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h10, 32'hFFFFFFFF, 4'h0);
    checks++; if (cnt != 1 || resp !== OKAY) begin failures++; $display("FAIL strb0_write got wen=%0d resp=%b want 1/%b", cnt, resp, OKAY); end
    axi_read(32'h10, 1, 1, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[4]) begin failures++; $display("FAIL strb0_rdata got=%h want=%h", rd, ref_mem[4]); end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic [31:0] rd; int cnt, ofs1, ofs2, idx; bit to;
    axi_write(32'h0, 32'hAAAAAAAA, 4'hF, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h0, 32'hAAAAAAAA, 4'hF);
    s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1;
    @(posedge clk); #1; s_wvalid = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if ({s_awready, s_wready, mem_wen} !== 3'b100) begin failures++; $display("FAIL wfirst_wait%0d got aw/w/wen=%b want=100", c, {s_awready, s_wready, mem_wen}); end
      @(posedge clk); #1;
    end
    s_awaddr = 32'h0; s_awvalid = 1;
    @(posedge clk); #1; s_awvalid = 0;
    checks++; if (mem_wen !== 1'b1 || mem_waddr !== 6'd0 || mem_wstrb !== 4'b0101 || mem_wdata !== 32'h11223344) begin failures++; $display("FAIL wfirst_commit got wen=%b idx=%0d strb=%b data=%h want 1/0/0101/11223344", mem_wen, mem_waddr, mem_wstrb, mem_wdata); end
    @(posedge clk); #1;
    checks++; if (s_bvalid !== 1'b1 || s_bresp !== OKAY) begin failures++; $display("FAIL wfirst_b got=%b/%b want=1/%b", s_bvalid, s_bresp, OKAY); end
    s_bready = 1; @(posedge clk); #1; s_bready = 0;
    ref_write(32'h0, 32'h11223344, 4'b0101);
    axi_read(32'h0, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[0]) begin failures++; $display("FAIL wfirst_rdata got=%h want=%h", rd, ref_mem[0]); end
  endtask

  task automatic test_backpressure();
    logic [1:0] b0; logic [31:0] d;
    d = $urandom;
    s_awaddr = 32'h20; s_wdata = d; s_wstrb = 4'hF; s_araddr = 32'h10;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 0; s_rready = 0;
    @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    ref_write(32'h20, d, 4'hF);
    @(posedge clk); #1;
    b0 = s_bresp;
    s_awaddr = 32'h30; s_awvalid = 1;
    for (int c = 0; c < 5; c++) begin
      checks++; if ({s_bvalid, s_rvalid} !== 2'b11 || s_bresp !== b0 || b0 !== OKAY) begin failures++; $display("FAIL bp_valid%0d got bv/rv=%b bresp=%b want 11/%b", c, {s_bvalid, s_rvalid}, s_bresp, OKAY); end
      checks++; if (s_rdata !== ref_mem[4] || s_rresp !== OKAY) begin failures++; $display("FAIL bp_rdata%0d got=%h want=%h", c, s_rdata, ref_mem[4]); end
      checks++; if ({s_awready, s_wready, s_arready, mem_wen, mem_ren} !== 5'b0) begin failures++; $display("FAIL bp_ready%0d got=%b want=00000", c, {s_awready, s_wready, s_arready, mem_wen, mem_ren}); end
      @(posedge clk); #1;
    end
    s_awvalid = 0; s_bready = 1; s_rready = 1;
    @(posedge clk); #1; s_bready = 0; s_rready = 0;
    checks++; if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b00111) begin failures++; $display("FAIL bp_release got=%b want=00111", {s_bvalid, s_rvalid, s_awready, s_wready, s_arready}); end
    $display("BP write idx=8 data=%h read idx=4 held 5 cycles", d);
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp; logic [31:0] rd, old; int cnt, ofs1, ofs2, idx; bit to;
    axi_write(32'h1C, 32'h99, 4'hF, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h1C, 32'h99, 4'hF);
    old = ref_mem[7];
    s_awaddr = 32'h1C; s_wdata = 32'h55; s_wstrb = 4'hF; s_araddr = 32'h1C;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
    @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    checks++; if ({mem_wen, mem_ren} !== 2'b11 || mem_waddr !== 6'd7 || mem_raddr !== 6'd7) begin failures++; $display("FAIL same_strobes got wen/ren=%b w=%0d r=%0d want 11/7/7", {mem_wen, mem_ren}, mem_waddr, mem_raddr); end
    @(posedge clk); #1;
    checks++; if (s_rvalid !== 1'b1 || s_rdata !== old || s_bvalid !== 1'b1) begin failures++; $display("FAIL same_rdata got rv=%b data=%h bv=%b want 1/%h/1", s_rvalid, s_rdata, s_bvalid, old); end
    @(posedge clk); #1; s_bready = 0; s_rready = 0;
    $display("SAME write idx=7 data=00000055 read data=%h", old);
    ref_write(32'h1C, 32'h55, 4'hF);
    axi_read(32'h1C, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[7]) begin failures++; $display("FAIL same_after got=%h want=%h", rd, ref_mem[7]); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [31:0] rd; int cnt, ofs1, ofs2, idx; bit to;
    s_awaddr = 32'h24; s_awvalid = 1;
    @(posedge clk); #1; s_awvalid = 0;
    checks++; if ({s_awready, s_wready} !== 2'b01) begin failures++; $display("FAIL rmid_have_aw got aw/w=%b want=01", {s_awready, s_wready}); end
    reset = 1;
    @(posedge clk); #1; reset = 0;
    checks++; if ({mem_wen, s_bvalid} !== 2'b00 || {s_awready, s_wready, s_arready} !== 3'b111) begin failures++; $display("FAIL rmid_after got wen/bv=%b rdy=%b want 00/111", {mem_wen, s_bvalid}, {s_awready, s_wready, s_arready}); end
    s_wdata = 32'h77; s_wstrb = 4'hF; s_wvalid = 1;
    @(posedge clk); #1; s_wvalid = 0;
    checks++; if ({mem_wen, s_awready, s_wready} !== 3'b010) begin failures++; $display("FAIL rmid_discard got wen/aw/w=%b want=010", {mem_wen, s_awready, s_wready}); end
    axi_write(32'h24, 32'h0, 4'h0, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h24, 32'h77, 4'hF);
    axi_read(32'h24, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[9]) begin failures++; $display("FAIL rmid_rdata got=%h want=%h", rd, ref_mem[9]); end
    // pending response is dropped by reset
    s_awaddr = 32'h28; s_wdata = 32'h1234; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    @(posedge clk); #1; s_awvalid = 0; s_wvalid = 0;
    ref_write(32'h28, 32'h1234, 4'hF);
    @(posedge clk); #1; reset = 1;
    checks++; if (s_bvalid !== 1'b1) begin failures++; $display("FAIL rmid_bv_pre got=%b want=1", s_bvalid); end
    @(posedge clk); #1; reset = 0;
    checks++; if (s_bvalid !== 1'b0) begin failures++; $display("FAIL rmid_bv_drop got=%b want=0", s_bvalid); end
  endtask

  task automatic test_addr();
    logic [1:0] resp; logic [31:0] rd; int cnt, ofs1, ofs2, idx; bit to;
    axi_write(32'h100, 32'h12345678, 4'hF, 0, 0, 0, resp, cnt, ofs1, ofs2, idx, to);
    ref_write(32'h100, 32'h12345678, 4'hF);
`ifdef AXIL_ADDR_CHECK_EN
    checks++; if (resp !== SLVERR || cnt != 0 || ofs2 != 2) begin failures++; $display("FAIL addr_wr_err got resp=%b wen=%0d bv=%0d want %b/0/2", resp, cnt, ofs2, SLVERR); end
    axi_read(32'h2, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (resp !== SLVERR || cnt != 0 || rd !== 32'd0 || ofs2 != 2) begin failures++; $display("FAIL addr_rd_err got resp=%b ren=%0d data=%h rv=%0d want %b/0/0/2", resp, cnt, rd, ofs2, SLVERR); end
`else
    checks++; if (resp !== OKAY || cnt != 1 || idx != 0) begin failures++; $display("FAIL addr_alias_wr got resp=%b wen=%0d idx=%0d want %b/1/0", resp, cnt, idx, OKAY); end
    axi_read(32'h2, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (resp !== OKAY || idx != 0) begin failures++; $display("FAIL addr_alias_rd got resp=%b idx=%0d want %b/0", resp, idx, OKAY); end
`endif
    axi_read(32'h0, 0, 0, rd, resp, cnt, ofs1, ofs2, idx, to);
    checks++; if (rd !== ref_mem[0]) begin failures++; $display("FAIL addr_word0 got=%h want=%h", rd, ref_mem[0]); end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] rd, wa, ra, d; logic [3:0] s; int cnt, ofs1, ofs2, idx; bit to;
    for (int n = 0; n < 30; n++) begin
`ifdef AXIL_ADDR_CHECK_EN
      wa = 32'($urandom_range(0, 63)) * 4;
      ra = ($urandom_range(0, 1) == 1) ? wa : 32'($urandom_range(0, 63)) * 4;
`else
      wa = $urandom;
      ra = ($urandom_range(0, 1) == 1) ? wa : $urandom;
`endif
      d = $urandom; s = 4'($urandom);
      axi_write(wa, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                resp, cnt, ofs1, ofs2, idx, to);
      ref_write(wa, d, s);
      checks++; if (to || resp !== OKAY || cnt != 1 || ofs1 != 1 || ofs2 != 2 || idx != ref_idx(wa)) begin failures++; $display("FAIL rand_wr%0d got to=%0d resp=%b wen=%0d/%0d bv=%0d idx=%0d want 0/%b/1/1/2/%0d", n, to, resp, cnt, ofs1, ofs2, idx, OKAY, ref_idx(wa)); end
      axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, resp, cnt, ofs1, ofs2, idx, to);
      checks++; if (to || rd !== ref_mem[ref_idx(ra)] || resp !== OKAY || ofs2 != 2) begin failures++; $display("FAIL rand_rd%0d got to=%0d data=%h resp=%b rv=%0d want 0/%h/%b/2", n, to, rd, resp, ofs2, ref_mem[ref_idx(ra)], OKAY); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
    reset = 1; mem_clear = 1;
    s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0; s_bready = 0;
    s_araddr = 0; s_arvalid = 0; s_rready = 0;
    test_reset();
    test_basic();
    test_w_first();
    test_backpressure();
    test_same_cycle();
    test_reset_mid();
    test_addr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
